relu_backprop: RTL and testbench
================================

# relu_backprop

Streaming ReLU gradient unit: the backward-pass counterpart of the combinational `relu` forward layer. During the forward pass it records one mask bit per tensor element, taken from that element's pre-activation sign. During the backward pass it streams incoming gradients through this mask: gradients pass where the forward ReLU passed, and are zeroed where it clamped. It sits between the downstream layer's gradient output and the upstream layer's gradient input. It uses the same flattened tensor ordering and 16-bit signed fixed-point format as the forward layers.

## Interface
Parameters:
- NUM_CHANNELS, 1, channel count (k)
- X_SIZE, 1, rows (i)
- Y_SIZE, 1, columns (j)
- Z_SIZE, 1, depth (z)
- Derived: N = NUM_CHANNELS*Z_SIZE*X_SIZE*Y_SIZE; CW = max(1, $clog2(N))

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- clear  in  1  sync abort; returns the block to CAPTURE
- fwd_valid  in  1  forward pre-activation element valid
- fwd_data  in  16  signed pre-activation element
- fwd_ready  out  1  block accepts fwd_data
- mask_full  out  1  all N mask bits captured; backward pass enabled
- grad_valid  in  1  incoming gradient valid
- grad_data  in  16  signed gradient element
- grad_ready  out  1  block accepts grad_data
- out_valid  out  1  masked gradient valid
- out_data  out  16  masked gradient
- out_last  out  1  marks element N-1 of the backward stream
- out_ready  in  1  consumer accepts out_data

## Operation
- Element order on both streams: flat index ((k*Z_SIZE+z)*X_SIZE+i)*Y_SIZE+j, with j fastest. This matches the forward layer's slice order.
- Storage: mask register array of N bits; mask[n] = ~fwd_data[15]. Zero counts as pass, matching the forward rule (bit 15 == 0 passes).
- FSM states:
  - CAPTURE (reset state): fwd_ready = 1; grad_ready = 0.
    - Each fwd handshake writes mask[wr_cnt] and increments wr_cnt.
    - When the element at wr_cnt == N-1 is accepted, the FSM moves to BACKWARD and wr_cnt resets to 0.
  - BACKWARD: fwd_ready = 0; mask_full = 1; grad_ready = !out_valid || out_ready.
    - Each grad handshake loads the output register: out_data = mask[rd_cnt] ? grad_data : 16'h0000; out_last = (rd_cnt == N-1).
    - rd_cnt then increments.
    - After the grad handshake at rd_cnt == N-1, the FSM moves to DRAIN and rd_cnt resets to 0.
  - DRAIN: fwd_ready = 0; grad_ready = 0; mask_full = 1.
    - Holds until the last element's output handshake (out_valid && out_ready && out_last), then moves to CAPTURE.
- Output register: out_valid sets on a grad handshake. It clears on an output handshake unless a new grad handshake happens in the same cycle, in which case it stays 1.
- Mask bits are not cleared between passes; every bit is overwritten in the next CAPTURE.
- clear: synchronous, highest priority after reset. Sets state = CAPTURE, wr_cnt = rd_cnt = 0, out_valid = 0, out_last = 0. Any in-flight element is dropped.
- No arithmetic on data; out_data is a pure 16-bit select. Counters are CW bits wide and wrap only through the explicit reset to 0 at N-1.

## Timing
- Reset values: state = CAPTURE, fwd_ready = 1, mask_full = 0, grad_ready = 0, out_valid = 0, out_data = 0, out_last = 0, wr_cnt = rd_cnt = 0. Mask contents are don't-care.
- Capture throughput: 1 element/cycle. mask_full rises the cycle after the Nth fwd handshake.
- Backward latency: 1 cycle from grad handshake to out_valid. Throughput is 1/cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, at most one element is held.
  - grad_ready drops the cycle after out_valid rises with out_ready low.
  - out_data and out_last stay stable while out_valid && !out_ready.
- N = 1: capture and backward each complete in a single handshake; out_last = 1 on every output.
- clear in the same cycle as a handshake: clear wins and the handshake has no effect.
- Reset mid-operation: all state returns to its reset value asynchronously.

## Test plan
- N=4 (X=2, Y=2), fwd = 0x0005, 0xFFFE, 0x0000, 0x8000. Then grad = 0x0010, 0x0020, 0x0030, 0x0040 with out_ready=1. Required out = 0x0010, 0x0000, 0x0030, 0x0000, with out_last only on the 4th, and the FSM back in CAPTURE one cycle after.
- Same pass with out_ready toggled 1,0,0,1,... Required: no loss or duplication of elements; grad_ready low whenever out_valid && !out_ready; out_data stable while stalled.
- Two consecutive passes, second fwd = 0x8001 ×4. Required: all-zero gradients out in pass 2, proving the mask is overwritten.
- Assert clear after 2 captured elements, then a full 4-element pass. Required: output matches the fresh-mask expectation; mask_full stays 0 until 4 new captures.
- grad_valid held high during CAPTURE. Required: grad_ready = 0 and out_valid stays 0. Then rst_n low mid-BACKWARD. Required: all outputs at reset values immediately.
- N=1 with fwd = 0x7FFF and grad = 0x1234. Required: out = 0x1234 with out_last = 1, then back in CAPTURE.

Source files
------------

// File: rtl/relu_backprop.sv
// rtl/relu_backprop.sv - streaming ReLU gradient mask: captures forward signs, gates backward gradients
module relu_backprop #(
  parameter int NUM_CHANNELS = 1,
  parameter int X_SIZE       = 1,
  parameter int Y_SIZE       = 1,
  parameter int Z_SIZE       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        fwd_valid,
  input  logic [15:0] fwd_data,
  output logic        fwd_ready,
  output logic        mask_full,
  input  logic        grad_valid,
  input  logic [15:0] grad_data,
  output logic        grad_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);

  localparam int N  = NUM_CHANNELS * Z_SIZE * X_SIZE * Y_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_CAPTURE  = 2'd0;
  localparam logic [1:0] S_BACKWARD = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [N-1:0]  mask_q, mask_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic fwd_hs, grad_hs, out_hs;
  logic fwd_data_unused;

  // Only the sign bit of the pre-activation matters for the mask.
  assign fwd_data_unused = &{1'b0, fwd_data[14:0]};

  assign fwd_ready  = (state_q == S_CAPTURE);
  assign mask_full  = (state_q != S_CAPTURE);
  assign grad_ready = (state_q == S_BACKWARD) && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;

  assign fwd_hs  = fwd_valid && fwd_ready;
  assign grad_hs = grad_valid && grad_ready;
  assign out_hs  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (clear) begin
      state_d     = S_CAPTURE;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (out_hs) out_valid_d = 1'b0;

      case (state_q)
        S_CAPTURE: begin
          if (fwd_hs) begin
            mask_d[wr_cnt_q] = ~fwd_data[15];
            if (wr_cnt_q == LAST) begin
              wr_cnt_d = '0;
              state_d  = S_BACKWARD;
            end else begin
              wr_cnt_d = wr_cnt_q + 1'b1;
            end
          end
        end
        S_BACKWARD: begin
          if (grad_hs) begin
            // A new load in the same cycle as an output handshake keeps out_valid high.
            out_valid_d = 1'b1;
            out_data_d  = mask_q[rd_cnt_q] ? grad_data : 16'h0000;
            out_last_d  = (rd_cnt_q == LAST);
            if (rd_cnt_q == LAST) begin
              rd_cnt_d = '0;
              state_d  = S_DRAIN;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_hs && out_last_q) state_d = S_CAPTURE;
        end
        default: state_d = S_CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CAPTURE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_relu_backprop.sv
// tb/tb_relu_backprop.sv - scoreboard bench for relu_backprop (N=4 and N=1 instances)
module tb_relu_backprop;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [15:0] fwd_data = '0;
  logic        fwd_ready, mask_full;
  logic        grad_valid = 1'b0;
  logic [15:0] grad_data = '0;
  logic        grad_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  logic        fwd_valid_b = 1'b0;
  logic [15:0] fwd_data_b = '0;
  logic        fwd_ready_b, mask_full_b;
  logic        grad_valid_b = 1'b0;
  logic [15:0] grad_data_b = '0;
  logic        grad_ready_b, out_valid_b, out_last_b;
  logic [15:0] out_data_b;
  logic        out_ready_b = 1'b1;

  int tests = 0;
  int fails = 0;

  // Reference model: one pass flag per element, plus expected-output queue.
  bit          ref_mask [N];
  int          ref_wr = 0;
  int          ref_rd = 0;
  logic [16:0] sb_q [$];

  int          or_mode = 0;
  int          cyc = 0;
  bit          stalled = 0;
  logic [15:0] held_data;
  logic        held_last;

  always #5 clk = ~clk;

  relu_backprop #(.NUM_CHANNELS(1), .X_SIZE(2), .Y_SIZE(2), .Z_SIZE(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_ready(fwd_ready), .mask_full(mask_full),
    .grad_valid(grad_valid), .grad_data(grad_data), .grad_ready(grad_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  relu_backprop dut_n1 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .fwd_valid(fwd_valid_b), .fwd_data(fwd_data_b), .fwd_ready(fwd_ready_b), .mask_full(mask_full_b),
    .grad_valid(grad_valid_b), .grad_data(grad_data_b), .grad_ready(grad_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .out_ready(out_ready_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 always-1, 1 pattern 1,0,0,1, 2 random, 3 always-0
  always @(posedge clk) begin
    #1;
    cyc++;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected outputs on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(held_data));
        chk("stall_last", 32'(out_last), 32'(held_last));
      end
      stalled = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            logic [16:0] e;
            e = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[15:0]));
            chk("out_last", 32'(out_last), 32'(e[16]));
          end
        end else begin
          chk("bp_grad_ready", 32'(grad_ready), 32'd0);
          stalled   = 1;
          held_data = out_data;
          held_last = out_last;
        end
      end
    end
  end

  task automatic send_fwd(input logic [15:0] d);
    bit acc = 0;
    fwd_valid = 1'b1;
    fwd_data  = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (fwd_ready) begin
        chk("mask_full_during_capture", 32'(mask_full), 32'd0);
        ref_mask[ref_wr] = ($signed(d) >= 0);
        ref_wr = (ref_wr + 1) % N;
        acc = 1;
      end
      @(posedge clk); #1;
    end
    fwd_valid = 1'b0;
    if (!acc) chk("fwd_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture_pass(input logic [63:0] v);
    for (int i = 0; i < N; i++) send_fwd(v[16*i +: 16]);
    @(negedge clk);
    chk("mask_full_after_capture", 32'(mask_full), 32'd1);
    chk("fwd_ready_after_capture", 32'(fwd_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_grad(input logic [15:0] g);
    bit acc = 0;
    grad_valid = 1'b1;
    grad_data  = g;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      if (grad_ready) begin
        sb_q.push_back({(ref_rd == N - 1), (ref_mask[ref_rd] ? g : 16'h0000)});
        ref_rd = (ref_rd + 1) % N;
        acc = 1;
      end
      @(posedge clk); #1;
    end
    grad_valid = 1'b0;
    if (!acc) chk("grad_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!out_valid && sb_q.size() == 0) done = 1;
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("back_in_capture", 32'(fwd_ready), 32'd1);
    chk("mask_full_cleared", 32'(mask_full), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic grad_pass(input logic [63:0] g, input int maxgap);
    for (int i = 0; i < N; i++) begin
      send_grad(g[16*i +: 16]);
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
    wait_drain();
  endtask

  task automatic n1_pass(input logic [15:0] d, input logic [15:0] g);
    fwd_valid_b = 1'b1; fwd_data_b = d;
    @(negedge clk);
    chk("n1_fwd_ready", 32'(fwd_ready_b), 32'd1);
    @(posedge clk); #1;
    fwd_valid_b = 1'b0;
    @(negedge clk);
    chk("n1_mask_full", 32'(mask_full_b), 32'd1);
    chk("n1_grad_ready", 32'(grad_ready_b), 32'd1);
    @(posedge clk); #1;
    grad_valid_b = 1'b1; grad_data_b = g;
    @(posedge clk); #1;
    grad_valid_b = 1'b0;
    @(negedge clk);
    chk("n1_out_valid", 32'(out_valid_b), 32'd1);
    chk("n1_out_data", 32'(out_data_b), 32'(($signed(d) >= 0) ? g : 16'h0000));
    chk("n1_out_last", 32'(out_last_b), 32'd1);
    @(negedge clk);
    chk("n1_back_capture", 32'(fwd_ready_b), 32'd1);
    chk("n1_out_valid_clr", 32'(out_valid_b), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rand_elem();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("rst_mask_full", 32'(mask_full), 32'd0);
    chk("rst_grad_ready", 32'(grad_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed pass, out_ready held high
    or_mode = 0;
    capture_pass({16'h8000, 16'h0000, 16'hFFFE, 16'h0005});
    grad_pass({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0);

    // Same pass under a 1,0,0,1 backpressure pattern
    or_mode = 1;
    capture_pass({16'h8000, 16'h0000, 16'hFFFE, 16'h0005});
    grad_pass({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0);

    // Second pass with all-negative activations overwrites the mask
    or_mode = 0;
    capture_pass({4{16'h8001}});
    grad_pass({16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1);

    // clear after two captures; the clear-cycle handshake must be dropped
    send_fwd(16'h8000);
    send_fwd(16'h8000);
    clear = 1'b1; fwd_valid = 1'b1; fwd_data = 16'h8000;
    @(posedge clk); #1;
    clear = 1'b0; fwd_valid = 1'b0;
    ref_wr = 0; ref_rd = 0; sb_q.delete();
    @(negedge clk);
    chk("clear_mask_full", 32'(mask_full), 32'd0);
    chk("clear_fwd_ready", 32'(fwd_ready), 32'd1);
    @(posedge clk); #1;
    capture_pass({16'h8000, 16'h7FFF, 16'h0001, 16'h0002});
    grad_pass({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 0);

    // grad_valid during CAPTURE must be ignored
    grad_valid = 1'b1; grad_data = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("capture_grad_ready", 32'(grad_ready), 32'd0);
      chk("capture_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    grad_valid = 1'b0;

    // Asynchronous reset mid-BACKWARD with an element held
    or_mode = 3;
    capture_pass({16'h0004, 16'h0003, 16'h0002, 16'h0001});
    send_grad(16'h1111);
    grad_valid = 1'b1; grad_data = 16'h2222;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("arst_mask_full", 32'(mask_full), 32'd0);
    chk("arst_grad_ready", 32'(grad_ready), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    grad_valid = 1'b0;
    ref_wr = 0; ref_rd = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    or_mode = 0;
    @(posedge clk); #1;

    // Randomized passes with random backpressure and gaps
    or_mode = 2;
    for (int p = 0; p < 8; p++) begin
      logic [63:0] fv, gv;
      for (int i = 0; i < N; i++) begin
        fv[16*i +: 16] = rand_elem();
        gv[16*i +: 16] = 16'($urandom);
      end
      capture_pass(fv);
      grad_pass(gv, 2);
    end
    or_mode = 0;

    // N=1 instance
    n1_pass(16'h7FFF, 16'h1234);
    n1_pass(16'h8000, 16'h5555);
    n1_pass(16'h0000, 16'hABCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
